// File: rtl/lut_interp_err_sweep_if.sv
// Purpose : groups the sweep-engine signals (control, interpolator/reference taps, statistics).
// Latency : n/a (wiring only); the engine's timing is documented in lut_interp_err_sweep.
// Backpr. : none; start/abort are level requests sampled by the engine, results are held.
// Ports   : master = controller/testbench side, slave = sweep engine side.
interface lut_interp_err_sweep_if;
  logic        start;
  logic        abort;
  logic [7:0]  sweep_x;
  logic [7:0]  interp_y;
  logic [7:0]  ref_y;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  max_err;
  logic [7:0]  max_err_x;
  logic [15:0] sum_err;
  logic [8:0]  mismatch_cnt;

  modport master (
    output start, abort, interp_y, ref_y,
    input  sweep_x, busy, done, aborted, max_err, max_err_x, sum_err, mismatch_cnt
  );

  modport slave (
    input  start, abort, interp_y, ref_y,
    output sweep_x, busy, done, aborted, max_err, max_err_x, sum_err, mismatch_cnt
  );
endinterface

// File: rtl/lut_interp_err_sweep.sv
// Purpose : sweeps codes 0..255 through the LUT interpolator and accumulates error stats vs the reference table.
// Latency : done pulses 258 cycles after the start edge; one code issued per cycle, one pair accumulated per cycle.
// Backpr. : none; start ignored while busy, abort ends a sweep early (stats keep partial values).
// Ports   : clk, rst_n (async active-low); bus (slave): start/abort in, sweep_x out, interp_y (comb) and
//           ref_y (1-cycle sync read) in, busy/done/aborted/max_err/max_err_x/sum_err/mismatch_cnt out.
module lut_interp_err_sweep (
  input  logic                  clk,
  input  logic                  rst_n,
  lut_interp_err_sweep_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t      state;
  logic [7:0]  x_r;
  logic        busy_r;
  logic        done_r;
  logic        aborted_r;
  logic [7:0]  max_err_r;
  logic [7:0]  max_err_x_r;
  logic [15:0] sum_err_r;
  logic [8:0]  mismatch_r;

  // Capture stage: interpolator result for the code issued last cycle,
  // waiting for the reference memory's 1-cycle read of the same code.
  logic [7:0]  y_q;
  logic [7:0]  x_q;
  logic        v_q;

  logic [8:0]  diff;
  logic [8:0]  ndiff;
  logic [7:0]  e;
  logic        abort_now;
  logic        acc_en;

  // 9-bit difference so the sign is explicit; magnitude never wraps.
  always_comb begin
    diff  = {1'b0, bus.ref_y} - {1'b0, y_q};
    ndiff = 9'd0 - diff;
    e     = diff[8] ? ndiff[7:0] : diff[7:0];
  end

  // An abort discards the pair that would otherwise be accumulated this cycle.
  assign abort_now = (state == SWEEP) && bus.abort;
  assign acc_en    = v_q && !abort_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_r         <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      max_err_r   <= 8'd0;
      max_err_x_r <= 8'd0;
      sum_err_r   <= 16'd0;
      mismatch_r  <= 9'd0;
      y_q         <= 8'd0;
      x_q         <= 8'd0;
      v_q         <= 1'b0;
    end else begin
      done_r <= 1'b0;

      // Only SWEEP issues codes, so only SWEEP fills the capture stage.
      v_q <= 1'b0;
      if (state == SWEEP && !bus.abort) begin
        y_q <= bus.interp_y;
        x_q <= x_r;
        v_q <= 1'b1;
      end

      if (acc_en) begin
        sum_err_r  <= sum_err_r + {8'd0, e};
        mismatch_r <= mismatch_r + {8'd0, (e != 8'd0)};
        // Strictly greater: ties keep the earliest (lowest) code.
        if (e > max_err_r) begin
          max_err_r   <= e;
          max_err_x_r <= x_q;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= SWEEP;
            busy_r      <= 1'b1;
            aborted_r   <= 1'b0;
            x_r         <= 8'd0;
            max_err_r   <= 8'd0;
            max_err_x_r <= 8'd0;
            sum_err_r   <= 16'd0;
            mismatch_r  <= 9'd0;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
            x_r       <= 8'd0;
          end else if (x_r == 8'd255) begin
            // Hold at 255 rather than wrapping into a second pass.
            state <= DRAIN;
          end else begin
            x_r <= x_r + 8'd1;
          end
        end
        DRAIN: begin
          // Last pair (code 255) is accumulated this cycle; abort no longer matters.
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          x_r    <= 8'd0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          x_r    <= 8'd0;
        end
      endcase
    end
  end

  assign bus.sweep_x      = x_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.aborted      = aborted_r;
  assign bus.max_err      = max_err_r;
  assign bus.max_err_x    = max_err_x_r;
  assign bus.sum_err      = sum_err_r;
  assign bus.mismatch_cnt = mismatch_r;

endmodule

// File: tb/tb_lut_interp_err_sweep.sv
// Purpose : testbench for lut_interp_err_sweep with table-driven interpolator/reference models.
// Latency : checks done at cycle 258 after the start edge, abort/reset responses one cycle later.
// Backpr. : n/a; bench drives start/abort/rst_n and models the 1-cycle reference memory.
module tb_lut_interp_err_sweep;

  logic clk;
  logic rst_n;

  lut_interp_err_sweep_if bus ();

  lut_interp_err_sweep dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ref_tab [256];
  logic [7:0] mdl_tab [256];

  // Interpolator is combinational; reference memory is a synchronous read.
  assign bus.interp_y = mdl_tab[bus.sweep_x];
  always @(posedge clk) bus.ref_y <= ref_tab[bus.sweep_x];

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected statistics over codes 0..n-1, straight from the definition.
  int exp_max, exp_x, exp_sum, exp_cnt;
  task automatic model(input int n);
    int d;
    exp_max = 0; exp_x = 0; exp_sum = 0; exp_cnt = 0;
    for (int k = 0; k < n; k++) begin
      d = int'(ref_tab[k]) - int'(mdl_tab[k]);
      if (d < 0) d = -d;
      exp_sum += d;
      if (d != 0) exp_cnt++;
      if (d > exp_max) begin
        exp_max = d;
        exp_x   = k;
      end
    end
  endtask

  task automatic chk_stats(input string tag, input int n);
    model(n);
    chk({tag, ".max_err"},   32'(bus.max_err),      32'(exp_max));
    chk({tag, ".max_err_x"}, 32'(bus.max_err_x),    32'(exp_x));
    chk({tag, ".sum_err"},   32'(bus.sum_err),      32'(exp_sum));
    chk({tag, ".mismatch"},  32'(bus.mismatch_cnt), 32'(exp_cnt));
  endtask

  // One sweep. abort_at/restart_at/rst_at are cycle numbers (0 = unused);
  // chain re-requests start in the done cycle.
  task automatic do_sweep(input string tag, input int abort_at, input int restart_at,
                          input int rst_at, input bit chain);
    int done_at;
    bit normal;
    bit got_done;
    normal  = (abort_at == 0) && (rst_at == 0);
    done_at = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b0;
    @(posedge clk);  // edge 0
    for (int c = 1; c <= 262; c++) begin
      @(negedge clk);
      if (bus.done && done_at == 0) done_at = c;
      if (c == 1) begin
        chk({tag, ".c1_busy"},    32'(bus.busy),    32'd1);
        chk({tag, ".c1_x"},       32'(bus.sweep_x), 32'd0);
        chk({tag, ".c1_sum"},     32'(bus.sum_err), 32'd0);
        chk({tag, ".c1_aborted"}, 32'(bus.aborted), 32'd0);
      end
      if (normal && c == 256) begin
        chk({tag, ".c256_x"},    32'(bus.sweep_x), 32'd255);
        chk({tag, ".c256_busy"}, 32'(bus.busy),    32'd1);
      end
      if (normal && c == 258) begin
        chk({tag, ".c258_busy"}, 32'(bus.busy), 32'd0);
        chk_stats(tag, 256);
      end
      if (abort_at != 0 && c == abort_at + 1) begin
        chk({tag, ".ab_busy"},    32'(bus.busy),    32'd0);
        chk({tag, ".ab_aborted"}, 32'(bus.aborted), 32'd1);
        chk({tag, ".ab_x"},       32'(bus.sweep_x), 32'd0);
        chk_stats({tag, ".ab"}, abort_at - 2);
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        chk({tag, ".rs_busy"},    32'(bus.busy),    32'd0);
        chk({tag, ".rs_x"},       32'(bus.sweep_x), 32'd0);
        chk({tag, ".rs_aborted"}, 32'(bus.aborted), 32'd0);
        chk_stats({tag, ".rs"}, 0);
      end
      if (chain && c == 259) begin
        chk({tag, ".ch_busy"}, 32'(bus.busy),    32'd1);
        chk({tag, ".ch_x0"},   32'(bus.sweep_x), 32'd0);
      end
      if (chain && c == 260) chk({tag, ".ch_x1"}, 32'(bus.sweep_x), 32'd1);
      bus.start = (c == restart_at) || (chain && c == 258);
      bus.abort = (c == abort_at);
      if (rst_at != 0 && c == rst_at) rst_n = 1'b0;
      if (rst_at != 0 && c == rst_at + 2) rst_n = 1'b1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk({tag, ".done_cycle"}, 32'(done_at), normal ? 32'd258 : 32'd0);
    if (abort_at != 0) chk({tag, ".aborted_hold"}, 32'(bus.aborted), 32'd1);
    if (chain) begin
      got_done = 1'b0;
      for (int w = 0; w < 400 && !got_done; w++) begin
        @(negedge clk);
        if (bus.done) got_done = 1'b1;
      end
      chk({tag, ".ch_done_seen"}, 32'(got_done), 32'd1);
      chk_stats({tag, ".ch2"}, 256);
    end
  endtask

  task automatic rand_tabs();
    for (int k = 0; k < 256; k++) begin
      ref_tab[k] = 8'($urandom_range(0, 255));
      mdl_tab[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : ref_tab[k];
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int k = 0; k < 256; k++) begin
      ref_tab[k] = 8'(k);
      mdl_tab[k] = 8'(k);
    end
    repeat (3) @(negedge clk);
    chk("rst.x",        32'(bus.sweep_x),      32'd0);
    chk("rst.busy",     32'(bus.busy),         32'd0);
    chk("rst.done",     32'(bus.done),         32'd0);
    chk("rst.aborted",  32'(bus.aborted),      32'd0);
    chk("rst.max",      32'(bus.max_err),      32'd0);
    chk("rst.max_x",    32'(bus.max_err_x),    32'd0);
    chk("rst.sum",      32'(bus.sum_err),      32'd0);
    chk("rst.mismatch", 32'(bus.mismatch_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal interpolator on random reference data.
    for (int k = 0; k < 256; k++) begin
      ref_tab[k] = 8'($urandom_range(0, 255));
      mdl_tab[k] = ref_tab[k];
    end
    do_sweep("ideal", 0, 0, 0, 1'b0);

    // y = x reference, y = x^1 model.
    for (int k = 0; k < 256; k++) begin
      ref_tab[k] = 8'(k);
      mdl_tab[k] = 8'(k ^ 1);
    end
    do_sweep("xor1", 0, 0, 0, 1'b0);

    // Two equal spikes: the lower code must be reported.
    for (int k = 0; k < 256; k++) begin
      ref_tab[k] = 8'($urandom_range(0, 55));
      mdl_tab[k] = ref_tab[k];
    end
    mdl_tab[77]  = ref_tab[77] + 8'd200;
    mdl_tab[150] = ref_tab[150] + 8'd200;
    do_sweep("spike", 0, 0, 0, 1'b0);

    // Full-scale error everywhere.
    for (int k = 0; k < 256; k++) begin
      ref_tab[k] = 8'd255;
      mdl_tab[k] = 8'd0;
    end
    do_sweep("full", 0, 0, 0, 1'b0);

    // Abort in cycle 100 with the x^1 model.
    for (int k = 0; k < 256; k++) begin
      ref_tab[k] = 8'(k);
      mdl_tab[k] = 8'(k ^ 1);
    end
    do_sweep("abort", 100, 0, 0, 1'b0);

    // Next sweep must clear aborted and stats (checked in cycle 1).
    rand_tabs();
    do_sweep("post_abort", 0, 0, 0, 1'b0);

    // Random abort point.
    rand_tabs();
    do_sweep("abort_rnd", $urandom_range(3, 250), 0, 0, 1'b0);

    // Start re-pulsed mid-sweep is ignored.
    rand_tabs();
    do_sweep("restart50", 0, 50, 0, 1'b0);

    // Reset mid-sweep.
    rand_tabs();
    do_sweep("rst120", 0, 0, 120, 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back sweep started in the done cycle.
    rand_tabs();
    do_sweep("chain", 0, 0, 0, 1'b1);
    repeat (3) @(negedge clk);

    // Extra random sweeps.
    for (int r = 0; r < 3; r++) begin
      rand_tabs();
      do_sweep("rand", 0, 0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
